// File: rtl/console_pkg.sv
// rtl/console_pkg.sv - shared geometry, control codes and FSM states for the UART text console
package console_pkg;

    localparam int COLS   = 120;
    localparam int ROWS   = 75;
    localparam int ADDR_W = 14;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [6:0] CLEAR_CHAR = 7'h20;
    localparam logic [6:0] COL_LAST   = 7'(COLS - 1);
    localparam logic [6:0] ROW_LAST   = 7'(ROWS - 1);

    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_FF = 8'h0C;

    typedef enum logic {
        S_CLEAR,
        S_IDLE
    } console_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/console_cursor.sv
// rtl/console_cursor.sv - cursor column/row tracking with incremental row_base address
module console_cursor
    import console_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_inc,
    input  logic              i_newline,
    input  logic              i_cr,
    input  logic              i_back,
    input  logic              i_home,
    output logic [6:0]        o_col,
    output logic [6:0]        o_row,
    output logic [ADDR_W-1:0] o_addr
);

    logic [ADDR_W-1:0] row_base;
    logic              adv_row;

    // Line wrap from the last column advances the row exactly like LF.
    assign adv_row = i_newline || (i_inc && (o_col == COL_LAST));
    assign o_addr  = row_base + ADDR_W'(o_col);

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_col    <= '0;
            o_row    <= '0;
            row_base <= '0;
        end else if (i_home) begin
            o_col    <= '0;
            o_row    <= '0;
            row_base <= '0;
        end else begin
            if (i_inc) begin
                o_col <= (o_col == COL_LAST) ? 7'd0 : o_col + 7'd1;
            end else if (i_cr) begin
                o_col <= '0;
            end else if (i_back && (o_col != 7'd0)) begin
                o_col <= o_col - 7'd1;
            end

            if (adv_row) begin
                if (o_row == ROW_LAST) begin
                    o_row    <= '0;
                    row_base <= '0;
                end else begin
                    o_row    <= o_row + 7'd1;
                    row_base <= row_base + ADDR_W'(COLS);
                end
            end
        end
    end

endmodule

// File: rtl/uart_text_console.sv
// rtl/uart_text_console.sv - UART byte stream to character buffer writer with echo
module uart_text_console
    import console_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_resetn,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_byte,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [6:0]        o_wr_data,
    output logic [6:0]        o_cur_col,
    output logic [6:0]        o_cur_row,
    output logic              o_busy,
    output logic              o_overrun,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_busy
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CELLS - 1);

    console_state_t    state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              slot_full;
    logic [7:0]        slot_byte;

    logic              accept;
    logic              printable;
    logic              is_cr;
    logic              is_lf;
    logic              is_bs;
    logic              is_ff;
    logic              echo_load;
    logic              slot_drain;
    logic              sweep_done;
    logic [ADDR_W-1:0] cur_addr;

    assign accept     = i_rx_valid && (state == S_IDLE);
    assign printable  = is_printable(i_rx_byte);
    assign is_cr      = (i_rx_byte == CODE_CR);
    assign is_lf      = (i_rx_byte == CODE_LF);
    assign is_bs      = (i_rx_byte == CODE_BS);
    assign is_ff      = (i_rx_byte == CODE_FF);
    assign echo_load  = accept && (printable || is_cr || is_lf || is_bs || is_ff);
    assign slot_drain = slot_full && !i_tx_busy;
    assign sweep_done = (state == S_CLEAR) && (clr_cnt == CLR_LAST);

    console_cursor u_cursor (
        .i_clk     (i_clk),
        .i_resetn  (i_resetn),
        .i_inc     (accept && printable),
        .i_newline (accept && is_lf),
        .i_cr      (accept && is_cr),
        .i_back    (accept && is_bs),
        .i_home    (sweep_done),
        .o_col     (o_cur_col),
        .o_row     (o_cur_row),
        .o_addr    (cur_addr)
    );

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            o_wr_en    <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
            o_busy     <= 1'b0;
            o_overrun  <= 1'b0;
            o_tx_start <= 1'b0;
            o_tx_byte  <= '0;
            slot_full  <= 1'b0;
            slot_byte  <= '0;
        end else begin
            o_wr_en    <= 1'b0;
            o_tx_start <= 1'b0;

            case (state)
                S_CLEAR: begin
                    o_busy    <= 1'b1;
                    o_wr_en   <= 1'b1;
                    o_wr_addr <= clr_cnt;
                    o_wr_data <= CLEAR_CHAR;
                    if (sweep_done) begin
                        state   <= S_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                end
                S_IDLE: begin
                    o_busy <= 1'b0;
                    if (accept) begin
                        if (printable) begin
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= cur_addr;
                            o_wr_data <= i_rx_byte[6:0];
                        end else if (is_bs && (o_cur_col != 7'd0)) begin
                            // Blank the cell the cursor is stepping back onto.
                            o_wr_en   <= 1'b1;
                            o_wr_addr <= cur_addr - 1'b1;
                            o_wr_data <= CLEAR_CHAR;
                        end else if (is_ff) begin
                            state   <= S_CLEAR;
                            clr_cnt <= '0;
                        end
                    end
                end
                default: state <= S_CLEAR;
            endcase

            if (slot_drain) begin
                o_tx_start <= 1'b1;
                o_tx_byte  <= slot_byte;
            end

            // A slot draining this cycle can take the new byte in the same cycle.
            if (echo_load) begin
                if (slot_full && i_tx_busy) begin
                    o_overrun <= 1'b1;
                end else begin
                    slot_full <= 1'b1;
                    slot_byte <= i_rx_byte;
                end
            end else if (slot_drain) begin
                slot_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_text_console.sv
// tb/tb_uart_text_console.sv - directed self-checking bench for uart_text_console
module tb_uart_text_console;

    logic        i_clk      = 1'b0;
    logic        i_resetn   = 1'b0;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_byte  = 8'h00;
    logic        i_tx_busy  = 1'b0;
    logic        o_wr_en;
    logic [13:0] o_wr_addr;
    logic [6:0]  o_wr_data;
    logic [6:0]  o_cur_col;
    logic [6:0]  o_cur_row;
    logic        o_busy;
    logic        o_overrun;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;

    int vectors     = 0;
    int miscompares = 0;

    always #5 i_clk = ~i_clk;

    uart_text_console dut (
        .i_clk      (i_clk),
        .i_resetn   (i_resetn),
        .i_rx_valid (i_rx_valid),
        .i_rx_byte  (i_rx_byte),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_cur_col  (o_cur_col),
        .o_cur_row  (o_cur_row),
        .o_busy     (o_busy),
        .o_overrun  (o_overrun),
        .o_tx_start (o_tx_start),
        .o_tx_byte  (o_tx_byte),
        .i_tx_busy  (i_tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_write(input string tag, input logic en, input int addr, input logic [6:0] data);
        check({tag, "_wr_en"}, 32'(o_wr_en), 32'(en));
        if (en) begin
            check({tag, "_wr_addr"}, 32'(o_wr_addr), 32'(addr));
            check({tag, "_wr_data"}, 32'(o_wr_data), 32'(data));
        end
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, 32'(o_cur_col), 32'(col));
        check({tag, "_row"}, 32'(o_cur_row), 32'(row));
    endtask

    // Called at a falling edge; returns at the next falling edge with the byte's effect visible.
    task automatic send(input logic [7:0] b);
        i_rx_byte  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    // Follows one full clear sweep; any rx strobe left pending is released on the first sample.
    task automatic sweep_check(input string tag);
        int n     = 0;
        int good  = 0;
        int guard = 0;
        while (!o_busy && guard < 20) begin
            @(negedge i_clk);
            i_rx_valid = 1'b0;
            guard++;
        end
        while (o_busy && guard < 10000) begin
            if (o_wr_en === 1'b1 && o_wr_addr === 14'(n) && o_wr_data === 7'h20)
                good++;
            n++;
            @(negedge i_clk);
            i_rx_valid = 1'b0;
            guard++;
        end
        check({tag, "_busy_cycles"}, 32'(n), 32'd9000);
        check({tag, "_clear_writes"}, 32'(good), 32'd9000);
        check({tag, "_wr_en_after"}, 32'(o_wr_en), 32'd0);
        check_cursor({tag, "_home"}, 0, 0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_wr_addr", 32'(o_wr_addr), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_tx_start", 32'(o_tx_start), 32'd0);
        check("rst_tx_byte", 32'(o_tx_byte), 32'd0);
        check_cursor("rst", 0, 0);

        i_resetn = 1'b1;
        sweep_check("boot");

        send(8'h41);
        check_write("A", 1'b1, 0, 7'h41);
        check_cursor("A", 1, 0);
        @(negedge i_clk);
        check("A_tx_start", 32'(o_tx_start), 32'd1);
        check("A_tx_byte", 32'(o_tx_byte), 32'h41);
        @(negedge i_clk);
        check("A_tx_start_end", 32'(o_tx_start), 32'd0);

        send(8'h0D);
        check_write("CR", 1'b0, 0, 7'h00);
        check_cursor("CR", 0, 0);

        repeat (3) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
        check_cursor("pos53", 5, 3);
        send(8'h08);
        check_write("BS", 1'b1, 364, 7'h20);
        check_cursor("BS", 4, 3);
        send(8'h0D);
        send(8'h08);
        check_write("BS_col0", 1'b0, 0, 7'h00);
        check_cursor("BS_col0", 0, 3);

        send(8'h01);
        check_write("ignored", 1'b0, 0, 7'h00);
        check_cursor("ignored", 0, 3);
        check("BS_echo_start", 32'(o_tx_start), 32'd1);
        check("BS_echo_byte", 32'(o_tx_byte), 32'h08);
        @(negedge i_clk);
        check("ignored_no_echo", 32'(o_tx_start), 32'd0);

        repeat (71) send(8'h0A);
        repeat (119) send(8'h78);
        check_cursor("pos_last", 119, 74);
        send(8'h5A);
        check_write("Z_last", 1'b1, 8999, 7'h5A);
        check_cursor("Z_wrap", 0, 0);
        repeat (74) send(8'h0A);
        check_cursor("row74", 0, 74);
        send(8'h0A);
        check_write("LF_wrap", 1'b0, 0, 7'h00);
        check_cursor("LF_wrap", 0, 0);
        check("no_overrun_yet", 32'(o_overrun), 32'd0);

        send(8'h0C);
        i_rx_byte  = 8'h42;
        i_rx_valid = 1'b1;
        sweep_check("ff");
        check("ff_overrun", 32'(o_overrun), 32'd1);

        send(8'h0C);
        repeat (50) @(negedge i_clk);
        i_resetn = 1'b0;
        #1;
        check("midrst_busy", 32'(o_busy), 32'd0);
        check("midrst_wr_en", 32'(o_wr_en), 32'd0);
        check("midrst_overrun", 32'(o_overrun), 32'd0);
        @(negedge i_clk);
        i_resetn = 1'b1;
        sweep_check("restart");

        i_tx_busy = 1'b1;
        send(8'h43);
        check_write("C", 1'b1, 0, 7'h43);
        check("C_overrun", 32'(o_overrun), 32'd0);
        send(8'h44);
        check_write("D", 1'b1, 1, 7'h44);
        check_cursor("CD", 2, 0);
        check("D_overrun", 32'(o_overrun), 32'd1);
        @(negedge i_clk);
        check("held_no_start", 32'(o_tx_start), 32'd0);
        i_tx_busy = 1'b0;
        @(negedge i_clk);
        check("C_echo_start", 32'(o_tx_start), 32'd1);
        check("C_echo_byte", 32'(o_tx_byte), 32'h43);
        @(negedge i_clk);
        check("C_echo_single", 32'(o_tx_start), 32'd0);
        @(negedge i_clk);
        check("D_echo_lost", 32'(o_tx_start), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
